// File: rtl/mcu_bus_initiator.sv
// Initiator end of the 8-bit parallel MCU bus: generates bus_clock, writes
// command/data bytes and performs turnaround plus single-byte reads.
module mcu_bus_initiator #(
  parameter int CLOCK_DIV  = 4,
  parameter int TURNAROUND = 2
) (
  input  logic       system_clock,
  input  logic       sys_reset_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_read,
  input  logic       tx_is_command,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_is_command,
  output logic       busy,
  output logic       bus_clock,
  output logic [7:0] bus_output,
  input  logic [7:0] bus_input,
  output logic       bus_direction,
  output logic       command_data_output,
  input  logic       command_data_input
);

  localparam int CNT_MAX = (CLOCK_DIV > TURNAROUND) ? CLOCK_DIV : TURNAROUND;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLOCK_DIV - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_LOW  = 3'd1,
    W_HIGH = 3'd2,
    W_HOLD = 3'd3,
    TURN   = 3'd4,
    R_LOW  = 3'd5,
    R_HIGH = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [7:0]       wr_data_r;
  logic [7:0]       wr_data_s;
  logic             wr_cmd_r;
  logic             wr_cmd_s;
  logic             accept_s;
  logic             cnt_last_s;
  logic             drive_s;
  logic             sample_s;

  logic             tx_ready_r;
  logic             rx_valid_r;
  logic [7:0]       rx_data_r;
  logic             rx_is_command_r;
  logic             bus_clock_r;
  logic [7:0]       bus_output_r;
  logic             bus_direction_r;
  logic             command_data_output_r;

  assign accept_s   = tx_valid && tx_ready_r;
  assign cnt_last_s = (cnt_r == CNT_ZERO);
  assign drive_s    = (state_s == W_LOW) || (state_s == W_HIGH) || (state_s == W_HOLD);
  assign sample_s   = (state_r == R_HIGH) && cnt_last_s;

  // Next-state, phase counter reload and write-byte latch.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_last_s ? cnt_r : (cnt_r - CNT_ONE);
    wr_data_s = wr_data_r;
    wr_cmd_s  = wr_cmd_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !tx_read) begin
          state_s   = W_LOW;
          cnt_s     = DIV_LOAD;
          wr_data_s = tx_data;
          wr_cmd_s  = tx_is_command;
        end else if (accept_s) begin
          if (TURNAROUND == 0) begin
            state_s = R_LOW;
            cnt_s   = DIV_LOAD;
          end else begin
            state_s = TURN;
            cnt_s   = TURN_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      W_LOW: begin
        if (cnt_last_s) begin
          state_s = W_HIGH;
          cnt_s   = DIV_LOAD;
        end else begin
          state_s = W_LOW;
        end
      end
      W_HIGH: begin
        if (cnt_last_s) begin
          state_s = W_HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = W_HIGH;
        end
      end
      W_HOLD: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
      TURN: begin
        if (cnt_last_s) begin
          state_s = R_LOW;
          cnt_s   = DIV_LOAD;
        end else begin
          state_s = TURN;
        end
      end
      R_LOW: begin
        if (cnt_last_s) begin
          state_s = R_HIGH;
          cnt_s   = DIV_LOAD;
        end else begin
          state_s = R_LOW;
        end
      end
      R_HIGH: begin
        if (cnt_last_s) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = R_HIGH;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and latched write byte.
  always_ff @(posedge system_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      wr_data_r <= 8'h00;
      wr_cmd_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      wr_data_r <= wr_data_s;
      wr_cmd_r  <= wr_cmd_s;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge system_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tx_ready_r            <= 1'b0;
      rx_valid_r            <= 1'b0;
      rx_data_r             <= 8'h00;
      rx_is_command_r       <= 1'b0;
      bus_clock_r           <= 1'b0;
      bus_output_r          <= 8'h00;
      bus_direction_r       <= 1'b0;
      command_data_output_r <= 1'b0;
    end else begin
      tx_ready_r            <= (state_s == IDLE);
      bus_clock_r           <= (state_s == W_HIGH) || (state_s == R_HIGH);
      bus_direction_r       <= drive_s;
      bus_output_r          <= drive_s ? wr_data_s : 8'h00;
      command_data_output_r <= drive_s ? wr_cmd_s : 1'b0;
      rx_valid_r            <= sample_s;
      if (sample_s) begin
        rx_data_r       <= bus_input;
        rx_is_command_r <= command_data_input;
      end else begin
        rx_data_r       <= rx_data_r;
        rx_is_command_r <= rx_is_command_r;
      end
    end
  end

  assign tx_ready            = tx_ready_r;
  assign busy                = !tx_ready_r;
  assign rx_valid            = rx_valid_r;
  assign rx_data             = rx_data_r;
  assign rx_is_command       = rx_is_command_r;
  assign bus_clock           = bus_clock_r;
  assign bus_output          = bus_output_r;
  assign bus_direction       = bus_direction_r;
  assign command_data_output = command_data_output_r;

endmodule

// File: tb/tb_mcu_bus_initiator.sv
// Directed bench for mcu_bus_initiator: one instance with CLOCK_DIV=4/TURNAROUND=2
// and one with CLOCK_DIV=1/TURNAROUND=0, each with a small responder model.
module tb_mcu_bus_initiator;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;

  logic       tx_valid = 1'b0, tx_read = 1'b0, tx_is_command = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, rx_valid, rx_is_command, busy;
  logic [7:0] rx_data, bus_output;
  logic       bus_clock, bus_direction, command_data_output;
  logic [7:0] bus_in = 8'hEE;
  logic       cd_in  = 1'b1;

  logic       b_tx_valid = 1'b0, b_tx_read = 1'b0;
  logic       b_tx_ready, b_rx_valid, b_rx_is_command, b_busy;
  logic [7:0] b_rx_data, b_bus_output;
  logic       b_bus_clock, b_bus_direction, b_command_data_output;
  logic [7:0] b_bus_in = 8'h11;
  logic       b_cd_in  = 1'b0;

  logic [7:0] resp_byte = 8'h00;
  logic       resp_cmd  = 1'b0;
  logic       resp_drv = 1'b0, b_resp_drv = 1'b0;
  logic [8:0] wr_log [0:31];
  int         wr_n = 0, pulse_n = 0, contention = 0;

  int n_chk = 0, n_bad = 0;
  logic [15:0] tr_clk, tr_dir, tr_rdy, tr_rxv;
  logic [8:0]  out_first, out_last;
  logic [4:0]  b_clk, b_dir, b_rxv;
  int base_wr, base_pulse, c, k, rxv_at;
  logic started, pend;

  always #5 clk = ~clk;

  mcu_bus_initiator #(.CLOCK_DIV(4), .TURNAROUND(2)) dut (
    .system_clock(clk), .sys_reset_n(rst_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_read(tx_read),
    .tx_is_command(tx_is_command), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_is_command(rx_is_command),
    .busy(busy), .bus_clock(bus_clock), .bus_output(bus_output),
    .bus_input(bus_in), .bus_direction(bus_direction),
    .command_data_output(command_data_output), .command_data_input(cd_in)
  );

  mcu_bus_initiator #(.CLOCK_DIV(1), .TURNAROUND(0)) dut_b (
    .system_clock(clk), .sys_reset_n(rst_n),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_read(b_tx_read),
    .tx_is_command(1'b0), .tx_data(8'h00),
    .rx_valid(b_rx_valid), .rx_data(b_rx_data), .rx_is_command(b_rx_is_command),
    .busy(b_busy), .bus_clock(b_bus_clock), .bus_output(b_bus_output),
    .bus_input(b_bus_in), .bus_direction(b_bus_direction),
    .command_data_output(b_command_data_output), .command_data_input(b_cd_in)
  );

  // Responder for dut: logs written bytes on the rising edge, otherwise drives until the falling edge.
  always @(bus_clock) begin
    if (bus_clock) begin
      pulse_n <= pulse_n + 1;
      if (bus_direction) begin
        if (wr_n < 32) wr_log[wr_n] <= {command_data_output, bus_output};
        wr_n <= wr_n + 1;
      end else begin
        bus_in   <= resp_byte;
        cd_in    <= resp_cmd;
        resp_drv <= 1'b1;
      end
    end else begin
      bus_in   <= 8'hEE;
      cd_in    <= ~resp_cmd;
      resp_drv <= 1'b0;
    end
  end

  // Responder for dut_b.
  always @(b_bus_clock) begin
    if (b_bus_clock) begin
      b_bus_in   <= 8'hC3;
      b_cd_in    <= 1'b1;
      b_resp_drv <= 1'b1;
    end else begin
      b_bus_in   <= 8'h11;
      b_cd_in    <= 1'b0;
      b_resp_drv <= 1'b0;
    end
  end

  // Contention monitor: initiator must never drive while a responder drives.
  always @(negedge clk) begin
    if ((bus_direction && resp_drv) || (b_bus_direction && b_resp_drv))
      contention <= contention + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input logic rd, input logic cmd, input logic [7:0] data,
                         input logic [7:0] resp, input logic resp_c);
    resp_byte = resp;
    resp_cmd  = resp_c;
    @(negedge clk);
    tx_read = rd; tx_is_command = cmd; tx_data = data; tx_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        tx_valid = 1'b0; tx_data = ~data; tx_is_command = ~cmd;
        out_first = {command_data_output, bus_output};
      end
      if (i == 9) out_last = {command_data_output, bus_output};
      tr_clk[i-1] = bus_clock;
      tr_dir[i-1] = bus_direction;
      tr_rdy[i-1] = tx_ready;
      tr_rxv[i-1] = rx_valid;
    end
  endtask

  task automatic set_item(input int idx);
    case (idx)
      0:       begin tx_read = 1'b0; tx_is_command = 1'b1; tx_data = 8'h01; end
      1:       begin tx_read = 1'b0; tx_is_command = 1'b0; tx_data = 8'h22; end
      default: begin tx_read = 1'b1; tx_is_command = 1'b0; tx_data = 8'h00; end
    endcase
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_ctl", {bus_clock, bus_direction, command_data_output, rx_valid,
                          rx_is_command, tx_ready, busy}, 7'b0000001);
    check_val("rst_data", {bus_output, rx_data}, 16'h0000);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_ready", {tx_ready, busy, b_tx_ready}, 3'b101);

    // Command write of A5; tx_data is scrambled right after accept.
    run_txn(1'b0, 1'b1, 8'hA5, 8'h00, 1'b0);
    check_val("wr_clk", tr_clk, 16'h00F0);
    check_val("wr_dir", tr_dir, 16'h01FF);
    check_val("wr_rdy", tr_rdy, 16'hFE00);
    check_val("wr_rxv", tr_rxv, 16'h0000);
    check_val("wr_out_c1", out_first, 9'h1A5);
    check_val("wr_out_c9", out_last, 9'h1A5);
    check_val("wr_seen", wr_log[wr_n-1], 9'h1A5);

    // Read with responder byte 3C, command_data 0.
    run_txn(1'b1, 1'b0, 8'h00, 8'h3C, 1'b0);
    check_val("rd_clk", tr_clk, 16'h03C0);
    check_val("rd_dir", tr_dir, 16'h0000);
    check_val("rd_rxv", tr_rxv, 16'h0400);
    check_val("rd_rdy", tr_rdy, 16'hFC00);
    check_val("rd_data", {rx_is_command, rx_data}, 9'h03C);

    // Back-to-back: cmd 01, data 22, read, tx_valid held high.
    resp_byte = 8'h96; resp_cmd = 1'b1;
    base_wr = wr_n; base_pulse = pulse_n;
    @(negedge clk);
    k = 0; set_item(0); tx_valid = 1'b1;
    started = 1'b0; pend = 1'b0; c = 0; rxv_at = -1;
    for (int n = 0; n < 80 && rxv_at < 0; n++) begin
      if (n > 0) @(negedge clk);
      if (started) c++;
      if (pend) begin
        pend = 1'b0; k++;
        if (k < 3) set_item(k);
        else tx_valid = 1'b0;
      end
      if (rx_valid) rxv_at = c;
      if (tx_valid && tx_ready) begin pend = 1'b1; started = 1'b1; end
    end
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("seq_rxv_cycle", rxv_at, 31);
    check_val("seq_pulses", pulse_n - base_pulse, 3);
    check_val("seq_wr0", wr_log[base_wr], 9'h101);
    check_val("seq_wr1", wr_log[base_wr+1], 9'h022);
    check_val("seq_rd", {rx_is_command, rx_data}, 9'h196);

    // Reset asserted during W_HIGH.
    @(negedge clk);
    tx_read = 1'b0; tx_is_command = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int n = 0; n < 40 && !bus_clock; n++) @(negedge clk);
    check_val("midrst_high_seen", bus_clock, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_ctl", {bus_clock, bus_direction, rx_valid, tx_ready, busy,
                             command_data_output}, 6'b000010);
    check_val("midrst_data", {bus_output, rx_data}, 16'h0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", {tx_ready, busy}, 2'b10);
    run_txn(1'b0, 1'b0, 8'h3E, 8'h00, 1'b0);
    check_val("post_wr_clk", tr_clk, 16'h00F0);
    check_val("post_wr_dir", tr_dir, 16'h01FF);
    check_val("post_wr_out", out_last, 9'h03E);
    check_val("post_wr_seen", wr_log[wr_n-1], 9'h03E);

    // CLOCK_DIV=1, TURNAROUND=0 read.
    @(negedge clk);
    b_tx_read = 1'b1; b_tx_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) b_tx_valid = 1'b0;
      b_clk[i-1] = b_bus_clock;
      b_dir[i-1] = b_bus_direction;
      b_rxv[i-1] = b_rx_valid;
    end
    check_val("fast_clk", b_clk, 5'b00010);
    check_val("fast_dir", b_dir, 5'b00000);
    check_val("fast_rxv", b_rxv, 5'b00100);
    check_val("fast_data", {b_rx_is_command, b_rx_data}, 9'h1C3);
    check_val("fast_idle", {b_busy, b_bus_output, b_command_data_output}, 10'h000);

    check_val("contention", contention, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mcu_bus_initiator.md
Name: mcu_bus_initiator

Overview:
- Initiator (MCU-side) end of the 8-bit parallel MCU bus whose responder lives inside msgpu.
- Generates the bus clock, drives command/data bytes with the command_data flag, and performs turnaround and byte reads from the responder.
- Used as the bus driver on bridge/test boards and as the bench driver for the msgpu responder. It runs on system_clock.

Parameters:
- CLOCK_DIV, 4, system_clock cycles per bus_clock half-period; legal range 1..255.
- TURNAROUND, 2, system_clock cycles with the bus released and bus_clock low before a read slot; 0 skips the TURN state.

Ports:
- system_clock  input  1  system clock; all logic is on the rising edge.
- sys_reset_n  input  1  asynchronous active-low reset.
- tx_valid  input  1  request valid.
- tx_ready  output  1  high only in IDLE; a request is accepted on tx_valid && tx_ready.
- tx_read  input  1  1 = read slot (release the bus, clock in one byte); 0 = write byte.
- tx_is_command  input  1  command_data value for a write; ignored for a read.
- tx_data  input  8  byte to write; ignored for a read.
- rx_valid  output  1  one-cycle pulse when a read byte is available.
- rx_data  output  8  last read byte; holds its value until the next read.
- rx_is_command  output  1  command_data_input sampled together with rx_data.
- busy  output  1  equal to !tx_ready.
- bus_clock  output  1  bus clock; idles low.
- bus_output  output  8  data driven to the bus.
- bus_input  input  8  bus pad input.
- bus_direction  output  1  1 = initiator drives the bus and command_data.
- command_data_output  output  1  1 = command byte, 0 = data byte.
- command_data_input  input  1  command_data pad input.

Behaviour:
- Reset is asynchronous and active-low (sys_reset_n). One clock, system_clock.
- Reset values:
  - bus_clock = 0, bus_direction = 0, bus_output = 0, command_data_output = 0.
  - rx_valid = 0, rx_data = 0, rx_is_command = 0, tx_ready = 0, busy = 1 while reset is asserted.
  - State goes to IDLE. The first cycle after release shows tx_ready = 1.
- Reset mid-transfer aborts the transfer immediately. No rx_valid is produced and the bus is released combinationally with reset.
- Protocol:
  - The responder samples on the bus_clock rising edge.
  - The initiator changes data only while bus_clock is low.
  - For reads, the responder drives after the rising edge. The initiator samples on the last system_clock cycle of the high phase.
- States: IDLE, W_LOW, W_HIGH, W_HOLD, TURN, R_LOW, R_HIGH.
  - Counter width is $clog2(max(CLOCK_DIV, TURNAROUND) + 1). The counter reloads on every state entry.
- IDLE:
  - bus_clock = 0, bus_direction = 0.
  - On accept with tx_read = 0: latch tx_data and tx_is_command, then go to W_LOW.
  - On accept with tx_read = 1: go to TURN, or to R_LOW if TURNAROUND = 0.
- W_LOW:
  - bus_direction = 1, bus_output = latched byte, command_data_output = latched flag, bus_clock = 0.
  - Lasts CLOCK_DIV cycles, then W_HIGH.
- W_HIGH: bus_clock = 1 for CLOCK_DIV cycles, then W_HOLD.
- W_HOLD: bus_clock = 0, data still driven, 1 cycle, then IDLE. Drive is released on entering IDLE.
- Write timing, with the accept edge at cycle 0:
  - bus_clock high during cycles 1+CLOCK_DIV .. 2*CLOCK_DIV.
  - Falling edge at cycle 1+2*CLOCK_DIV.
  - tx_ready = 1 again at cycle 2+2*CLOCK_DIV.
- TURN: bus_direction = 0, bus_clock = 0 for TURNAROUND cycles, then R_LOW.
- R_LOW: bus_direction = 0, bus_clock = 0 for CLOCK_DIV cycles, then R_HIGH.
- R_HIGH:
  - bus_clock = 1 for CLOCK_DIV cycles.
  - On the last cycle, register bus_input into rx_data and command_data_input into rx_is_command, with rx_valid = 1 the following cycle.
  - Then go to IDLE (bus_clock = 0 in that same cycle).
- Read latency: accept at cycle 0 gives rx_valid and tx_ready = 1 at cycle 1+TURNAROUND+2*CLOCK_DIV.
- Back-to-back transfers:
  - tx_valid held high with new data is accepted in the first IDLE cycle.
  - The minimum gap between bus_clock pulses is 2 low-phase system_clock cycles plus CLOCK_DIV.
- bus_direction is never 1 in TURN, R_LOW or R_HIGH. No bus contention is permitted.
- tx_data changing after accept has no effect on an in-flight write.

Test Plan:
- Reset, then write with tx_is_command = 1, tx_data = 8'hA5, CLOCK_DIV = 4:
  - One bus_clock pulse, high during cycles 5..8.
  - bus_output = A5, command_data_output = 1, bus_direction = 1 during cycles 1..9.
  - tx_ready = 1 at cycle 10.
- Read with TURNAROUND = 2, bench responder driving 8'h3C and command_data = 0 from the rising edge:
  - bus_direction = 0 throughout.
  - rx_valid is a single pulse at cycle 11 with rx_data = 3C, rx_is_command = 0.
- Sequence write cmd 8'h01, write data 8'h22, read, with tx_valid held continuously:
  - Three bus_clock pulses, no idle stall beyond the IDLE cycle.
  - Bench sees 01(cmd) then 22(data), and rx_data equals the responder byte.
- sys_reset_n asserted during W_HIGH:
  - bus_clock, bus_direction and rx_valid go to 0 the same cycle, without waiting for an edge.
  - After release, tx_ready = 1 and a new write completes normally.
- CLOCK_DIV = 1, TURNAROUND = 0, read:
  - Completes in 3 cycles (rx_valid at cycle 3).
  - Assertion over the run: bus_direction is never 1 while the responder drives.
